exc_fetch_ctrl: RTL and testbench

- Parametrised fetch/decode/exception sequencer for the multicycle MIPS datapath.
- Drives instruction fetch with a configurable memory latency, holds a configurable decode period, and hands off to the execution FSM through a start/done handshake.
- Owns the exception entry sequence: EPC capture, vector-byte read, PC redirect. Covers invalid opcode, divide-by-zero and overflow.

---
 rtl/exc_fetch_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_exc_fetch_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_fetch_ctrl.sv
// Fetch/decode/exception sequencer for the multicycle MIPS datapath.
// Runs instruction fetch with a configurable memory latency, holds the decode
// period, hands off to the execution FSM, and performs the exception entry
// sequence (EPC capture, vector-byte read, PC redirect).
// Every output is registered: the next state and next cycle count are resolved
// combinationally, and the outputs for that (state, count) are registered
// together with it. As a result, the outputs always describe the cycle that
// state_o shows.
module exc_fetch_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int MEM_LAT      = 3,
  parameter int DECODE_CYC   = 2,
  parameter int EXC_VEC_BASE = 253
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [7:0]        mem_byte_i,
  input  logic              exec_done_i,
  input  logic              bad_op_i,
  input  logic              div0_i,
  input  logic              ovf_i,
  output logic [1:0]        iord_o,
  output logic [ADDR_W-1:0] exc_addr_o,
  output logic              mem_wr_o,
  output logic              pc_inc_o,
  output logic              ir_write_o,
  output logic              pc_write_o,
  output logic [1:0]        pc_src_o,
  output logic [ADDR_W-1:0] pc_next_o,
  output logic              ab_write_o,
  output logic              exec_start_o,
  output logic              epc_write_o,
  output logic [ADDR_W-1:0] epc_o,
  output logic [1:0]        exc_cause_o,
  output logic [2:0]        state_o,
  output logic              reset_out
);

  typedef enum logic [2:0] {
    S_RESET   = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_EXC_RD  = 3'd4,
    S_EXC_JMP = 3'd5
  } state_t;

  // The counter must reach the longest fixed phase (FETCH has MEM_LAT+1 cycles).
  localparam int CNT_SPAN = (MEM_LAT + 1 > DECODE_CYC) ? MEM_LAT + 1 : DECODE_CYC;
  localparam int CNT_W    = $clog2(CNT_SPAN + 1);

  localparam logic [CNT_W-1:0] FETCH_LAST  = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] DECODE_LAST = CNT_W'(DECODE_CYC - 1);
  localparam logic [CNT_W-1:0] EXC_RD_LAST = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t            state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic              exc_take;
  logic [1:0]        cause_n;
  logic [ADDR_W-1:0] epc_n;
  logic [1:0]        iord_n;
  logic [ADDR_W-1:0] exc_addr_n;
  logic              pc_inc_n;
  logic              ir_write_n;
  logic              pc_write_n;
  logic [1:0]        pc_src_n;
  logic [ADDR_W-1:0] pc_next_n;
  logic              ab_write_n;
  logic              exec_start_n;
  logic              reset_out_n;

  assign state_o = state_q;

  // Next state, cycle count, exception capture and the outputs of the next cycle.
  always_comb begin
    state_n      = state_q;
    cnt_n        = cnt_q;
    exc_take     = 1'b0;
    cause_n      = exc_cause_o;
    epc_n        = epc_o;
    iord_n       = 2'b00;
    exc_addr_n   = '0;
    pc_inc_n     = 1'b0;
    ir_write_n   = 1'b0;
    pc_write_n   = 1'b0;
    pc_src_n     = 2'b00;
    pc_next_n    = '0;
    ab_write_n   = 1'b0;
    exec_start_n = 1'b0;
    reset_out_n  = 1'b0;

    case (state_q)
      S_RESET:  state_n = S_FETCH;
      S_FETCH:  if (cnt_q == FETCH_LAST) state_n = S_DECODE;
      S_DECODE: if (cnt_q == DECODE_LAST) state_n = S_EXEC;
      S_EXEC: begin
        // Exceptions take priority over completion; bad_op > div0 > ovf.
        if (bad_op_i) begin
          exc_take = 1'b1;
          cause_n  = 2'b01;
          state_n  = S_EXC_RD;
        end else if (div0_i) begin
          exc_take = 1'b1;
          cause_n  = 2'b10;
          state_n  = S_EXC_RD;
        end else if (ovf_i) begin
          exc_take = 1'b1;
          cause_n  = 2'b11;
          state_n  = S_EXC_RD;
        end else if (exec_done_i) begin
          state_n  = S_FETCH;
        end
      end
      S_EXC_RD:  if (cnt_q == EXC_RD_LAST) state_n = S_EXC_JMP;
      S_EXC_JMP: state_n = S_FETCH;
      default:   state_n = S_RESET;
    endcase

    if (exc_take) epc_n = pc_i - ADDR_W'(4);

    // Count restarts on every state change and saturates rather than wrapping.
    if (state_n != state_q) begin
      cnt_n = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_n = cnt_q + CNT_W'(1);
    end

    case (state_n)
      S_RESET: begin
        // Recovery from an unreachable encoding behaves like a reset.
        reset_out_n = 1'b1;
        cause_n     = 2'b00;
        epc_n       = '0;
      end
      S_FETCH: begin
        pc_inc_n = 1'b1;
        if (cnt_n == FETCH_LAST) begin
          ir_write_n = 1'b1;
          pc_write_n = 1'b1;
        end
      end
      S_DECODE: ab_write_n = 1'b1;
      S_EXEC:   exec_start_n = (cnt_n == '0);
      S_EXC_RD: begin
        iord_n     = 2'b01;
        exc_addr_n = ADDR_W'(EXC_VEC_BASE) + ADDR_W'(cause_n) - ADDR_W'(1);
      end
      S_EXC_JMP: begin
        // The vector byte is on the bus during the last read cycle.
        pc_next_n  = {{(ADDR_W-8){1'b0}}, mem_byte_i};
        pc_src_n   = 2'b01;
        pc_write_n = 1'b1;
      end
      default: reset_out_n = 1'b1;
    endcase
  end

  // State, counter and output registers; reset forces every output low except reset_out.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_RESET;
      cnt_q        <= '0;
      iord_o       <= 2'b00;
      exc_addr_o   <= '0;
      mem_wr_o     <= 1'b0;
      pc_inc_o     <= 1'b0;
      ir_write_o   <= 1'b0;
      pc_write_o   <= 1'b0;
      pc_src_o     <= 2'b00;
      pc_next_o    <= '0;
      ab_write_o   <= 1'b0;
      exec_start_o <= 1'b0;
      epc_write_o  <= 1'b0;
      epc_o        <= '0;
      exc_cause_o  <= 2'b00;
      reset_out    <= 1'b1;
    end else begin
      state_q      <= state_n;
      cnt_q        <= cnt_n;
      iord_o       <= iord_n;
      exc_addr_o   <= exc_addr_n;
      mem_wr_o     <= 1'b0;
      pc_inc_o     <= pc_inc_n;
      ir_write_o   <= ir_write_n;
      pc_write_o   <= pc_write_n;
      pc_src_o     <= pc_src_n;
      pc_next_o    <= pc_next_n;
      ab_write_o   <= ab_write_n;
      exec_start_o <= exec_start_n;
      epc_write_o  <= exc_take;
      epc_o        <= epc_n;
      exc_cause_o  <= cause_n;
      reset_out    <= reset_out_n;
    end
  end

endmodule

// File: tb/tb_exc_fetch_ctrl.sv
// Self-checking bench for exc_fetch_ctrl: directed scenarios with literal
// expectations followed by randomized traffic, all compared every cycle
// against a timeline model of the fetch/decode/exception sequence.
module tb_exc_fetch_ctrl;

  localparam int ADDR_W       = 32;
  localparam int MEM_LAT      = 3;
  localparam int DECODE_CYC   = 2;
  localparam int EXC_VEC_BASE = 253;

  logic        clk;
  logic        reset;
  logic [31:0] pc_i;
  logic [7:0]  mem_byte_i;
  logic        exec_done_i, bad_op_i, div0_i, ovf_i;
  logic [1:0]  iord_o;
  logic [31:0] exc_addr_o;
  logic        mem_wr_o, pc_inc_o, ir_write_o, pc_write_o;
  logic [1:0]  pc_src_o;
  logic [31:0] pc_next_o;
  logic        ab_write_o, exec_start_o, epc_write_o;
  logic [31:0] epc_o;
  logic [1:0]  exc_cause_o;
  logic [2:0]  state_o;
  logic        reset_out;

  int n_tests = 0;
  int n_fail  = 0;

  exc_fetch_ctrl #(
    .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .DECODE_CYC(DECODE_CYC), .EXC_VEC_BASE(EXC_VEC_BASE)
  ) dut (
    .clk(clk), .reset(reset), .pc_i(pc_i), .mem_byte_i(mem_byte_i),
    .exec_done_i(exec_done_i), .bad_op_i(bad_op_i), .div0_i(div0_i), .ovf_i(ovf_i),
    .iord_o(iord_o), .exc_addr_o(exc_addr_o), .mem_wr_o(mem_wr_o), .pc_inc_o(pc_inc_o),
    .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .pc_src_o(pc_src_o),
    .pc_next_o(pc_next_o), .ab_write_o(ab_write_o), .exec_start_o(exec_start_o),
    .epc_write_o(epc_write_o), .epc_o(epc_o), .exc_cause_o(exc_cause_o),
    .state_o(state_o), .reset_out(reset_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Timeline model: the expected per-cycle picture of each fixed-length phase
  // is queued up in advance; only the open-ended EXEC phase is decided cycle
  // by cycle from the inputs.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [2:0]  st;
    logic [1:0]  iord;
    logic        pc_inc;
    logic        ir_w;
    logic        pc_w;
    logic [1:0]  pc_src;
    logic        ab_w;
    logic        start;
    logic [31:0] xaddr;
    logic [31:0] pnext;
  } rec_t;

  rec_t        q[$];
  rec_t        cur;
  bit          m_valid   = 0;
  bit          m_in_exec = 0;
  bit          m_in_rst  = 1;
  logic [1:0]  m_cause   = 2'b00;
  logic [31:0] m_epc     = 32'h0;
  bit          m_epcw    = 0;
  bit          m_rsto    = 1;

  function automatic rec_t mk(input logic [2:0] st);
    rec_t r;
    r    = '0;
    r.st = st;
    return r;
  endfunction

  task automatic push_fetch_decode();
    rec_t r;
    for (int i = 0; i <= MEM_LAT; i++) begin
      r = mk(3'd1);
      r.pc_inc = 1'b1;
      if (i == MEM_LAT) begin
        r.ir_w = 1'b1;
        r.pc_w = 1'b1;
      end
      q.push_back(r);
    end
    for (int i = 0; i < DECODE_CYC; i++) begin
      r = mk(3'd2);
      r.ab_w = 1'b1;
      q.push_back(r);
    end
  endtask

  task automatic model_step();
    rec_t r;
    m_epcw  = 0;
    m_valid = 1;
    if (reset) begin
      q.delete();
      m_in_exec = 0;
      m_in_rst  = 1;
      cur       = mk(3'd0);
      m_cause   = 2'b00;
      m_epc     = 32'h0;
      m_rsto    = 1;
    end else if (m_in_rst) begin
      m_in_rst = 0;
      m_rsto   = 0;
      push_fetch_decode();
      cur = q.pop_front();
    end else begin
      if (m_in_exec) begin
        if (bad_op_i || div0_i || ovf_i) begin
          m_cause   = bad_op_i ? 2'b01 : (div0_i ? 2'b10 : 2'b11);
          m_epc     = pc_i - 32'd4;
          m_epcw    = 1;
          m_in_exec = 0;
          for (int i = 0; i < MEM_LAT; i++) begin
            r = mk(3'd4);
            r.iord  = 2'b01;
            r.xaddr = 32'(EXC_VEC_BASE) + 32'(m_cause) - 32'd1;
            q.push_back(r);
          end
          r = mk(3'd5);
          r.pc_src = 2'b01;
          r.pc_w   = 1'b1;
          q.push_back(r);
          push_fetch_decode();
        end else if (exec_done_i) begin
          m_in_exec = 0;
          push_fetch_decode();
        end
      end
      if (m_in_exec) begin
        cur = mk(3'd3);
      end else if (q.size() == 0) begin
        m_in_exec = 1;
        cur       = mk(3'd3);
        cur.start = 1'b1;
      end else begin
        cur = q.pop_front();
        if (cur.st == 3'd5) cur.pnext = {24'h0, mem_byte_i};
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare process: every output against the model, mid-cycle.
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("state",      32'(state_o),      32'(cur.st));
      chk("iord",       32'(iord_o),       32'(cur.iord));
      chk("pc_inc",     32'(pc_inc_o),     32'(cur.pc_inc));
      chk("ir_write",   32'(ir_write_o),   32'(cur.ir_w));
      chk("pc_write",   32'(pc_write_o),   32'(cur.pc_w));
      chk("pc_src",     32'(pc_src_o),     32'(cur.pc_src));
      chk("ab_write",   32'(ab_write_o),   32'(cur.ab_w));
      chk("exec_start", 32'(exec_start_o), 32'(cur.start));
      chk("exc_addr",   exc_addr_o,        cur.xaddr);
      chk("pc_next",    pc_next_o,         cur.pnext);
      chk("epc_write",  32'(epc_write_o),  32'(m_epcw));
      chk("epc",        epc_o,             m_epc);
      chk("exc_cause",  32'(exc_cause_o),  32'(m_cause));
      chk("reset_out",  32'(reset_out),    32'(m_rsto));
      chk("mem_wr",     32'(mem_wr_o),     32'd0);
    end
  end

  task automatic wait_exec();
    for (int i = 0; i < 40 && !m_in_exec; i++) @(negedge clk);
    chk("wait_exec_timeout", 32'(m_in_exec), 32'd1);
  endtask

  // Stimulus plus literal expectations for the directed scenarios.
  initial begin
    reset = 1'b1; pc_i = 32'h0; mem_byte_i = 8'h0;
    exec_done_i = 1'b0; bad_op_i = 1'b0; div0_i = 1'b0; ovf_i = 1'b0;

    // Reset held two cycles, then released.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_state", 32'(state_o), 32'd0);
      chk("rst_reset_out", 32'(reset_out), 32'd1);
      chk("rst_pc_write", 32'(pc_write_o), 32'd0);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rel_fetch_state", 32'(state_o), 32'd1);
      chk("rel_ir_write", 32'(ir_write_o), 32'(i == 3));
      chk("rel_pc_write", 32'(pc_write_o), 32'(i == 3));
      chk("rel_reset_out", 32'(reset_out), 32'd0);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rel_decode_state", 32'(state_o), 32'd2);
      chk("rel_ab_write", 32'(ab_write_o), 32'd1);
    end
    @(negedge clk);
    chk("rel_exec_state", 32'(state_o), 32'd3);
    chk("rel_exec_start", 32'(exec_start_o), 32'd1);

    // Normal completion three cycles after exec_start.
    repeat (3) @(negedge clk);
    chk("done_start_once", 32'(exec_start_o), 32'd0);
    exec_done_i = 1'b1;
    @(negedge clk);
    exec_done_i = 1'b0;
    chk("done_fetch", 32'(state_o), 32'd1);
    chk("done_epc_write", 32'(epc_write_o), 32'd0);
    chk("done_cause", 32'(exc_cause_o), 32'd0);

    // Overflow at pc 0x10 with vector byte 0x40.
    wait_exec();
    pc_i = 32'h0000_0010; ovf_i = 1'b1;
    @(negedge clk);
    ovf_i = 1'b0; mem_byte_i = 8'h40;
    chk("ovf_state", 32'(state_o), 32'd4);
    chk("ovf_epc_write", 32'(epc_write_o), 32'd1);
    chk("ovf_epc", epc_o, 32'h0000_000C);
    chk("ovf_cause", 32'(exc_cause_o), 32'd3);
    chk("ovf_iord", 32'(iord_o), 32'd1);
    chk("ovf_addr0", exc_addr_o, 32'd255);
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      chk("ovf_rd_state", 32'(state_o), 32'd4);
      chk("ovf_addr", exc_addr_o, 32'd255);
    end
    @(negedge clk);
    chk("ovf_jmp_state", 32'(state_o), 32'd5);
    chk("ovf_pc_next", pc_next_o, 32'h0000_0040);
    chk("ovf_pc_src", 32'(pc_src_o), 32'd1);
    chk("ovf_pc_write", 32'(pc_write_o), 32'd1);
    @(negedge clk);
    chk("ovf_back_fetch", 32'(state_o), 32'd1);
    chk("ovf_epc_hold", epc_o, 32'h0000_000C);

    // bad_op, div0 and exec_done together: bad_op wins, no early FETCH.
    wait_exec();
    bad_op_i = 1'b1; div0_i = 1'b1; exec_done_i = 1'b1;
    @(negedge clk);
    bad_op_i = 1'b0; div0_i = 1'b0; exec_done_i = 1'b0;
    chk("prio_cause", 32'(exc_cause_o), 32'd1);
    chk("prio_addr", exc_addr_o, 32'd253);
    chk("prio_state", 32'(state_o), 32'd4);
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      chk("prio_rd_state", 32'(state_o), 32'd4);
    end
    @(negedge clk);
    chk("prio_jmp_state", 32'(state_o), 32'd5);
    @(negedge clk);
    chk("prio_fetch", 32'(state_o), 32'd1);

    // ovf held high through FETCH and DECODE is ignored.
    ovf_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ign_fetch_state", 32'(state_o), 32'd1);
      chk("ign_epc_write", 32'(epc_write_o), 32'd0);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("ign_decode_state", 32'(state_o), 32'd2);
      chk("ign_epc_write", 32'(epc_write_o), 32'd0);
    end
    ovf_i = 1'b0;
    @(negedge clk);
    chk("ign_exec_start", 32'(exec_start_o), 32'd1);
    exec_done_i = 1'b1;
    @(negedge clk);
    exec_done_i = 1'b0;
    chk("ign_fetch_again", 32'(state_o), 32'd1);

    // Reset during the second EXC_RD cycle.
    wait_exec();
    div0_i = 1'b1;
    @(negedge clk);
    div0_i = 1'b0;
    chk("mid_cause", 32'(exc_cause_o), 32'd2);
    @(negedge clk);
    chk("mid_rd1", 32'(state_o), 32'd4);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_state", 32'(state_o), 32'd0);
    chk("mid_reset_out", 32'(reset_out), 32'd1);
    chk("mid_epc", epc_o, 32'd0);
    chk("mid_cause0", 32'(exc_cause_o), 32'd0);
    chk("mid_iord", 32'(iord_o), 32'd0);
    chk("mid_addr", exc_addr_o, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_fetch", 32'(state_o), 32'd1);
    chk("mid_iord_pc", 32'(iord_o), 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset       = ($urandom_range(0, 199) == 0);
      exec_done_i = ($urandom_range(0, 5) == 0);
      bad_op_i    = ($urandom_range(0, 15) == 0);
      div0_i      = ($urandom_range(0, 15) == 0);
      ovf_i       = ($urandom_range(0, 15) == 0);
      pc_i        = $urandom;
      mem_byte_i  = 8'($urandom);
    end
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
